// File: rtl/mpc_arb.sv
// mpc_arb: two-requester round-robin arbiter in front of a shared mpc datapath.
// Each operation takes three cycles: grant (IDLE edge), result capture (EXEC
// edge) and completion bookkeeping (DONE edge).
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   req0/1     operation requests, held until the matching grant is seen
//   instr0/1   18-bit instructions: [17:16] opcode, [15:8] opr2, [7:0] opr1
//   gnt0/1     one-cycle grant pulses (high only while in EXEC)
//   alu_instr  registered instruction presented to the datapath
//   alu_out    combinational datapath result
//   result     registered result of the last completed operation
//   valid      one-cycle pulse marking result/owner valid
//   owner      requester id of the operation in flight or just completed
//   done_cnt   8-bit wrapping count of completed operations
module mpc_arb (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [17:0] instr0,
  output logic        gnt0,
  input  logic        req1,
  input  logic [17:0] instr1,
  output logic        gnt1,
  output logic [17:0] alu_instr,
  input  logic [8:0]  alu_out,
  output logic [8:0]  result,
  output logic        valid,
  output logic        owner,
  output logic [7:0]  done_cnt
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]  r_state;
  logic        r_gnt0;
  logic        r_gnt1;
  logic [17:0] r_alu_instr;
  logic [8:0]  r_result;
  logic        r_valid;
  logic        r_owner;
  logic        r_last_owner;
  logic [7:0]  r_done_cnt;

  logic        w_any_req;
  logic        w_winner;
  logic [17:0] w_win_instr;

  assign w_any_req   = req0 | req1;
  // Under contention the requester not granted last wins; otherwise the lone requester wins.
  assign w_winner    = (req0 && req1) ? ~r_last_owner : req1;
  assign w_win_instr = w_winner ? instr1 : instr0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_alu_instr  <= '0;
      r_result     <= '0;
      r_valid      <= 1'b0;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;  // requester 0 wins the first contention
      r_done_cnt   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_gnt0       <= ~w_winner;
            r_gnt1       <= w_winner;
            r_alu_instr  <= w_win_instr;
            r_owner      <= w_winner;
            r_last_owner <= w_winner;
            r_state      <= StExec;
          end
        end
        StExec: begin
          r_gnt0   <= 1'b0;
          r_gnt1   <= 1'b0;
          r_result <= alu_out;
          r_valid  <= 1'b1;
          r_state  <= StDone;
        end
        StDone: begin
          r_valid    <= 1'b0;
          r_done_cnt <= r_done_cnt + 8'd1;  // wraps 255 -> 0
          r_state    <= StIdle;
        end
        default: begin
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_valid <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign alu_instr = r_alu_instr;
  assign result    = r_result;
  assign valid     = r_valid;
  assign owner     = r_owner;
  assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_mpc_arb.sv
// Testbench for mpc_arb: transaction-level reference model feeding a scoreboard,
// with an independent monitor checking grant/valid cycles and payloads.
module tb_mpc_arb;

  logic        clk;
  logic        reset;
  logic        req0;
  logic [17:0] instr0;
  logic        gnt0;
  logic        req1;
  logic [17:0] instr1;
  logic        gnt1;
  logic [17:0] alu_instr;
  logic [8:0]  alu_out;
  logic [8:0]  result;
  logic        valid;
  logic        owner;
  logic [7:0]  done_cnt;

  mpc_arb dut (
    .clk      (clk),
    .reset    (reset),
    .req0     (req0),
    .instr0   (instr0),
    .gnt0     (gnt0),
    .req1     (req1),
    .instr1   (instr1),
    .gnt1     (gnt1),
    .alu_instr(alu_instr),
    .alu_out  (alu_out),
    .result   (result),
    .valid    (valid),
    .owner    (owner),
    .done_cnt (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath semantics: 9-bit arithmetic on zero-extended operands.
  function automatic logic [8:0] dp(input logic [17:0] i);
    logic [8:0] a;
    logic [8:0] b;
    a = {1'b0, i[7:0]};
    b = {1'b0, i[15:8]};
    case (i[17:16])
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a + 9'd1;
      default: return a - 9'd1;
    endcase
  endfunction

  always_comb alu_out = dp(alu_instr);

  typedef struct {
    int          cyc;
    logic        own;
    logic [17:0] ins;
    logic [8:0]  res;
    logic [7:0]  dcnt;
  } exp_t;

  exp_t gq[$];
  exp_t vq[$];
  logic obs_owner[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit spacing_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the arbiter decides once free, then is busy for two more edges.
  int   m_busy;
  logic m_last;
  logic [7:0] m_cnt;
  exp_t m_e;
  logic m_w;
  initial begin
    m_busy = 0;
    m_last = 1'b1;
    m_cnt  = 8'd0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (reset) begin
        gq.delete();
        vq.delete();
        m_busy = 0;
        m_last = 1'b1;
        m_cnt  = 8'd0;
      end else if (m_busy > 0) begin
        m_busy--;
      end else if (req0 || req1) begin
        m_w      = (req0 && req1) ? !m_last : req1;
        m_e.cyc  = cyc;
        m_e.own  = m_w;
        m_e.ins  = m_w ? instr1 : instr0;
        m_e.res  = dp(m_e.ins);
        m_e.dcnt = m_cnt;
        gq.push_back(m_e);
        m_e.cyc  = cyc + 1;
        vq.push_back(m_e);
        m_cnt    = m_cnt + 8'd1;
        m_last   = m_w;
        m_busy   = 2;
      end
    end
  end

  // Monitor: samples on the falling edge and compares against the scoreboard.
  exp_t mon_e;
  int   last_v;
  initial begin
    last_v = -1;
    forever begin
      @(negedge clk);
      check("gnt_exclusive", {31'd0, gnt0 & gnt1}, 32'd0);
      while (gq.size() > 0 && gq[0].cyc < cyc) begin
        mon_e = gq.pop_front();
        check("gnt_missing", 32'd0, 32'd1);
      end
      if (gq.size() > 0 && gq[0].cyc == cyc) begin
        mon_e = gq.pop_front();
        check("gnt0", {31'd0, gnt0}, {31'd0, !mon_e.own});
        check("gnt1", {31'd0, gnt1}, {31'd0, mon_e.own});
        check("owner_at_gnt", {31'd0, owner}, {31'd0, mon_e.own});
        check("alu_instr", {14'd0, alu_instr}, {14'd0, mon_e.ins});
      end else begin
        check("no_gnt", {30'd0, gnt0, gnt1}, 32'd0);
      end
      while (vq.size() > 0 && vq[0].cyc < cyc) begin
        mon_e = vq.pop_front();
        check("valid_missing", 32'd0, 32'd1);
      end
      if (vq.size() > 0 && vq[0].cyc == cyc) begin
        mon_e = vq.pop_front();
        check("valid", {31'd0, valid}, 32'd1);
        check("result", {23'd0, result}, {23'd0, mon_e.res});
        check("owner", {31'd0, owner}, {31'd0, mon_e.own});
        check("alu_instr_hold", {14'd0, alu_instr}, {14'd0, mon_e.ins});
        check("done_cnt_at_valid", {24'd0, done_cnt}, {24'd0, mon_e.dcnt});
        obs_owner.push_back(owner);
      end else begin
        check("no_valid", {31'd0, valid}, 32'd0);
      end
      if (!spacing_en) last_v = -1;
      else if (valid) begin
        if (last_v >= 0) check("valid_spacing", cyc - last_v, 32'd3);
        last_v = cyc;
      end
    end
  end

  // Stimulus.
  bit hold;
  task automatic step();
    @(negedge clk);
    if (!hold) begin
      if (gnt0) req0 = 1'b0;
      if (gnt1) req1 = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  int  n_gnt;
  bit  seen;
  logic [31:0] rnd;

  initial begin
    hold   = 0;
    reset  = 1'b1;
    req0   = 1'b0;
    req1   = 1'b0;
    instr0 = '0;
    instr1 = '0;
    idle(3);
    check("rst_gnt", {30'd0, gnt0, gnt1}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_result", {23'd0, result}, 32'd0);
    check("rst_alu_instr", {14'd0, alu_instr}, 32'd0);
    check("rst_owner", {31'd0, owner}, 32'd0);
    check("rst_done_cnt", {24'd0, done_cnt}, 32'd0);
    reset = 1'b0;

    // Single add.
    req0   = 1'b1;
    instr0 = 18'b00_00000101_00000011;
    idle(6);
    check("add_result", {23'd0, result}, 32'h008);
    check("add_done_cnt", {24'd0, done_cnt}, 32'd1);

    // Contention with both requests held after reset.
    reset = 1'b1;
    step();
    reset = 1'b0;
    obs_owner.delete();
    hold   = 1;
    req0   = 1'b1;
    req1   = 1'b1;
    instr0 = {2'b01, 8'd5, 8'd3};
    instr1 = {2'b10, 8'h00, 8'hFF};
    n_gnt  = 0;
    for (int i = 0; i < 40 && n_gnt < 4; i++) begin
      step();
      if (gnt0 || gnt1) n_gnt++;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    hold = 0;
    idle(6);
    check("contend_ops", obs_owner.size(), 32'd4);
    for (int i = 0; i < 4 && i < obs_owner.size(); i++)
      check("contend_alternation", {31'd0, obs_owner[i]}, i % 2);

    // Decrement underflow from requester 1 only.
    req1   = 1'b1;
    rnd    = $urandom;
    instr1 = {2'b11, rnd[7:0], 8'h00};
    seen   = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (gnt0) seen = 1;
    end
    check("dec_no_gnt0", {31'd0, seen}, 32'd0);
    check("dec_result", {23'd0, result}, 32'h1FF);
    check("dec_owner", {31'd0, owner}, 32'd1);

    // Reset asserted during the EXEC cycle.
    req0   = 1'b1;
    instr0 = 18'($urandom);
    seen   = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (gnt0) seen = 1;
    end
    check("abort_got_gnt", {31'd0, seen}, 32'd1);
    reset = 1'b1;
    step();
    check("abort_valid", {31'd0, valid}, 32'd0);
    check("abort_gnt", {30'd0, gnt0, gnt1}, 32'd0);
    check("abort_done_cnt", {24'd0, done_cnt}, 32'd0);
    reset = 1'b0;
    idle(5);

    // 256 back-to-back operations; instructions churn every cycle.
    reset = 1'b1;
    step();
    reset = 1'b0;
    hold  = 1;
    req0  = 1'b1;
    req1  = 1'b1;
    spacing_en = 1;
    n_gnt = 0;
    for (int i = 0; i < 1000 && n_gnt < 256; i++) begin
      instr0 = 18'($urandom);
      instr1 = 18'($urandom);
      step();
      if (gnt0 || gnt1) n_gnt++;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    hold = 0;
    idle(5);
    spacing_en = 0;
    check("wrap_ops", n_gnt, 32'd256);
    check("wrap_done_cnt", {24'd0, done_cnt}, 32'd0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      reset = 1'b0;
      if ($urandom_range(0, 199) == 0) reset = 1'b1;
      if (!req0 && !gnt0 && $urandom_range(0, 3) == 0) begin
        req0 = 1'b1;
        instr0 = 18'($urandom);
      end else if (req0 && $urandom_range(0, 2) == 0) begin
        instr0 = 18'($urandom);
      end
      if (!req1 && !gnt1 && $urandom_range(0, 3) == 0) begin
        req1 = 1'b1;
        instr1 = 18'($urandom);
      end else if (req1 && $urandom_range(0, 2) == 0) begin
        instr1 = 18'($urandom);
      end
      step();
    end
    reset = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    for (int i = 0; i < 20 && (gq.size() > 0 || vq.size() > 0); i++) step();
    check("drain_gq", gq.size(), 32'd0);
    check("drain_vq", vq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
